// File: rtl/la_pkg.sv
// Shared definitions for the logic-analysis capture path: frame bytes,
// datapath widths and frame packer state encodings.
package la_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;

  localparam logic [BYTE_W-1:0] HDR_BYTE_DEF = 8'hA5;
  localparam logic [BYTE_W-1:0] TRL_BYTE_DEF = 8'h5A;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_HDR   = 3'd1;
  localparam state_t ST_RD    = 3'd2;
  localparam state_t ST_LAT   = 3'd3;
  localparam state_t ST_BYTES = 3'd4;
  localparam state_t ST_TRL   = 3'd5;
  localparam state_t ST_CNT_H = 3'd6;
  localparam state_t ST_CNT_L = 3'd7;

endpackage

// File: rtl/la_byte_serializer.sv
// Holds one FIFO word and the registered tx byte/valid pair; the frame
// packer either loads a word, steps to the next byte, or presents a fixed byte.
module la_byte_serializer
  import la_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  input  logic              put,
  input  logic [BYTE_W-1:0] put_byte,
  input  logic              drop,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              last_c
);

  logic [WORD_W-1:0] shreg;
  logic [2:0]        idx;
  logic [2:0]        idx_dec;

  assign idx_dec = idx - 3'd1;
  assign last_c  = (idx == 3'd0);

  // Priority load > shift > put > drop; only one is raised per cycle anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      idx      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shreg    <= load_data;
      idx      <= 3'd7;
      tx_data  <= load_data[WORD_W-1 -: BYTE_W];
      tx_valid <= 1'b1;
    end else if (shift) begin
      idx      <= idx_dec;
      tx_data  <= shreg[{idx_dec, 3'b000} +: BYTE_W];
    end else if (put) begin
      tx_data  <= put_byte;
      tx_valid <= 1'b1;
    end else if (drop) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/la_frame_packer.sv
// Drains the 64-bit sample FIFO into a framed byte stream:
// header, payload (MSB byte first), trailer, 16-bit word count.
module la_frame_packer
  import la_pkg::*;
#(
  parameter logic [7:0]  HDR_BYTE   = HDR_BYTE_DEF,
  parameter logic [7:0]  TRL_BYTE   = TRL_BYTE_DEF,
  parameter int unsigned DONE_GUARD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [WORD_W-1:0] fifo_rdata,
  input  logic              capture_done,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
);

  localparam int unsigned GUARD_W = 8;

  state_t             state;
  state_t             state_next;
  logic               done_pend;
  logic [GUARD_W-1:0] guard;
  logic               accept;
  logic               drained;
  logic               load;
  logic               shift;
  logic               put;
  logic [BYTE_W-1:0]  put_byte;
  logic               drop;
  logic               clr_cnt;
  logic               inc_cnt;
  logic               last_c;

  assign accept     = tx_valid && tx_ready;
  assign drained    = done_pend && (guard == '0) && fifo_empty;
  // Read strobe is decoded so the word lands exactly in LAT.
  assign fifo_rd_en = (state == ST_RD) && !fifo_empty;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    put        = 1'b0;
    put_byte   = '0;
    drop       = 1'b0;
    clr_cnt    = 1'b0;
    inc_cnt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty || drained) begin
          state_next = ST_HDR;
          clr_cnt    = 1'b1;
          put        = 1'b1;
          put_byte   = HDR_BYTE;
        end
      end
      ST_HDR: begin
        if (accept) begin
          if (drained) begin
            state_next = ST_TRL;
            put        = 1'b1;
            put_byte   = TRL_BYTE;
          end else begin
            state_next = ST_RD;
            drop       = 1'b1;
          end
        end
      end
      ST_RD: begin
        if (!fifo_empty) begin
          state_next = ST_LAT;
        end else if (drained) begin
          state_next = ST_TRL;
          put        = 1'b1;
          put_byte   = TRL_BYTE;
        end
      end
      ST_LAT: begin
        state_next = ST_BYTES;
        load       = 1'b1;
        inc_cnt    = 1'b1;
      end
      ST_BYTES: begin
        if (accept) begin
          if (last_c) begin
            state_next = ST_RD;
            drop       = 1'b1;
          end else begin
            shift = 1'b1;
          end
        end
      end
      ST_TRL: begin
        if (accept) begin
          state_next = ST_CNT_H;
          put        = 1'b1;
          put_byte   = word_count[15:8];
        end
      end
      ST_CNT_H: begin
        if (accept) begin
          state_next = ST_CNT_L;
          put        = 1'b1;
          put_byte   = word_count[7:0];
        end
      end
      ST_CNT_L: begin
        if (accept) begin
          state_next = ST_IDLE;
          drop       = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A capture_done coinciding with TRL entry stays pending for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      done_pend  <= 1'b0;
      guard      <= '0;
      word_count <= '0;
      busy       <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
      if (capture_done) begin
        done_pend <= 1'b1;
      end else if ((state_next == ST_TRL) && (state != ST_TRL)) begin
        done_pend <= 1'b0;
      end
      if (capture_done) begin
        guard <= GUARD_W'(DONE_GUARD);
      end else if (guard != '0) begin
        guard <= guard - GUARD_W'(1);
      end
      if (clr_cnt) begin
        word_count <= '0;
      end else if (inc_cnt && (word_count != '1)) begin
        word_count <= word_count + CNT_W'(1);
      end
    end
  end

  la_byte_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (fifo_rdata),
    .shift     (shift),
    .put       (put),
    .put_byte  (put_byte),
    .drop      (drop),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .last_c    (last_c)
  );

endmodule

// File: tb/tb_la_frame_packer.sv
// Scoreboard bench for la_frame_packer: a behavioural FIFO feeds words,
// expected frame bytes are queued at stimulus time and popped on each accept.
module tb_la_frame_packer;

  logic        clk;
  logic        rst;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [63:0] fifo_rdata = '0;
  logic        capture_done;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [15:0] word_count;

  logic [63:0] fifo_q[$];
  logic [7:0]  exp_q[$];
  logic        wr_en;
  logic [63:0] wr_data;
  logic        fifo_flush;
  logic        rand_ready;
  logic        rd_seen = 1'b0;
  logic        stalled = 1'b0;
  logic [7:0]  held = '0;
  logic        prev_rd = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  int          base;

  la_frame_packer dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rdata   (fifo_rdata),
    .capture_done (capture_done),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .word_count   (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Behavioural sample FIFO: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (fifo_flush) begin
      fifo_q.delete();
    end else begin
      if (rd_seen) begin
        check("rd_nonempty", 64'(fifo_q.size() > 0), 64'd1);
        if (fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
      end
      if (wr_en) fifo_q.push_back(wr_data);
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  always begin
    @(posedge clk);
    #1;
    tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    rd_seen = fifo_rd_en;
    if (rst) begin
      stalled = 1'b0;
      prev_rd = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", 64'(tx_valid), 64'd1);
        check("hold_data", 64'(tx_data), 64'(held));
      end
      if (tx_valid && tx_ready) begin
        check("byte_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
        acc_cnt++;
      end
      if (fifo_rd_en) check("rd_gap", 64'(prev_rd), 64'd0);
      stalled = tx_valid && !tx_ready;
      held    = tx_data;
      prev_rd = fifo_rd_en;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached limit 500000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [63:0] w);
    wr_data = w;
    wr_en   = 1'b1;
    for (int i = 7; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_done();
    capture_done = 1'b1;
    tick();
    capture_done = 1'b0;
  endtask

  task automatic push_tail(input logic [15:0] n);
    exp_q.push_back(8'h5A);
    exp_q.push_back(n[15:8]);
    exp_q.push_back(n[7:0]);
  endtask

  task automatic wait_frame(input int max_cyc);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < max_cyc) begin
      tick();
      k++;
    end
    check("frame_busy", 64'(busy), 64'd0);
    check("frame_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_acc(input int target, input int max_cyc);
    int k;
    k = 0;
    while (acc_cnt < target && k < max_cyc) begin
      tick();
      k++;
    end
    if (acc_cnt < target) check("acc_wait", 64'(acc_cnt), 64'(target));
  endtask

  initial begin
    rst          = 1'b1;
    capture_done = 1'b0;
    wr_en        = 1'b0;
    wr_data      = '0;
    fifo_flush   = 1'b0;
    rand_ready   = 1'b0;
    repeat (3) tick();
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    rst = 1'b0;
    tick();

    // Two words, ready held high.
    exp_q.push_back(8'hA5);
    write_word(64'h0102030405060708);
    write_word(64'h1112131415161718);
    pulse_done();
    push_tail(16'd2);
    wait_frame(200);
    check("count_two", 64'(word_count), 64'd2);

    // Same stream with a randomly stalling transmitter.
    rand_ready = 1'b1;
    exp_q.push_back(8'hA5);
    write_word(64'h0102030405060708);
    write_word(64'h1112131415161718);
    pulse_done();
    push_tail(16'd2);
    wait_frame(800);
    rand_ready = 1'b0;
    tick();
    check("count_rand", 64'(word_count), 64'd2);

    // Empty capture.
    exp_q.push_back(8'hA5);
    pulse_done();
    push_tail(16'd0);
    wait_frame(100);
    repeat (10) tick();
    check("empty_idle_busy", 64'(busy), 64'd0);
    check("empty_count", 64'(word_count), 64'd0);

    // Final write lands one cycle after capture_done while FIFO is empty.
    base = acc_cnt;
    exp_q.push_back(8'hA5);
    write_word(64'h2122232425262728);
    wait_acc(base + 9, 100);
    tick();
    pulse_done();
    write_word(64'h3132333435363738);
    push_tail(16'd2);
    wait_frame(200);
    check("count_late", 64'(word_count), 64'd2);

    // Reset while the fourth payload byte is on the bus.
    base = acc_cnt;
    exp_q.push_back(8'hA5);
    write_word(64'h0102030405060708);
    write_word(64'h1112131415161718);
    wait_acc(base + 4, 100);
    check("mid_byte", 64'(tx_data), 64'h04);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(tx_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_count", 64'(word_count), 64'd0);
    exp_q.delete();
    fifo_flush = 1'b1;
    tick();
    fifo_flush = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    exp_q.push_back(8'hA5);
    write_word(64'hC1C2C3C4C5C6C7C8);
    pulse_done();
    push_tail(16'd1);
    wait_frame(200);
    check("count_after_rst", 64'(word_count), 64'd1);

    // Saturation: preload the count just below the limit mid-frame.
    base = acc_cnt;
    exp_q.push_back(8'hA5);
    write_word(64'hD1D2D3D4D5D6D7D8);
    wait_acc(base + 9, 100);
    tick();
    force dut.word_count = 16'hFFFE;
    tick();
    release dut.word_count;
    write_word(64'hE1E2E3E4E5E6E7E8);
    write_word(64'hF1F2F3F4F5F6F7F8);
    pulse_done();
    push_tail(16'hFFFF);
    wait_frame(300);
    check("count_sat", 64'(word_count), 64'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
